f_predict: RTL and testbench



---
 rtl/f_predict.sv | 138 +++++++++++++
 tb/tb_f_predict.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/f_predict.sv
// Fetch-stage branch target buffer with 2-bit predictor state.
// Each entry holds {valid, state[1:0], tag, target}. A post-reset sweep zeroes
// every entry before fetch predictions are trusted. Reads are write-first, so
// the read register always mirrors the current table entry for pc_q.
module f_predict #(
  parameter  int PC_W    = 13,
  parameter  int ADDR_W  = 11,
  localparam int TAG_W   = PC_W - ADDR_W,
  localparam int ENTRY_W = 1 + 2 + TAG_W + PC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc,
  input  logic               stall,
  output logic               ready,
  output logic [PC_W-1:0]    pc_q,
  output logic [PC_W-1:0]    pc_predicted,
  output logic               hit,
  output logic [1:0]         state_out,
  input  logic [ENTRY_W-1:0] w_data,
  input  logic [ADDR_W-1:0]  w_addr,
  input  logic               wen
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   cnt, cnt_d;
  logic                ready_d;

  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [ENTRY_W-1:0]  rd_q;

  // Effective write port: the sweep owns it in CLEAR, the resolver in RUN.
  logic                we;
  logic [ADDR_W-1:0]   wa;
  logic [ENTRY_W-1:0]  wd;

  logic [ADDR_W-1:0]   pc_idx;
  logic [ADDR_W-1:0]   q_idx;

  logic                e_valid;
  logic [1:0]          e_state;
  logic [TAG_W-1:0]    e_tag;
  logic [PC_W-1:0]     e_target;

  assign pc_idx = pc[ADDR_W-1:0];
  assign q_idx  = pc_q[ADDR_W-1:0];

  // Sweep controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of block ordering.
      state <= state_d;
      cnt   <= cnt_d;
      ready <= ready_d;
    end
  end

  // Sweep next-state: step the index each cycle; leave CLEAR after the last entry.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d = state;
    cnt_d   = cnt;
    ready_d = ready;
    case (state)
      CLEAR: begin
        cnt_d = cnt + ADDR_W'(1);
        if (&cnt) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN:     ;
      default: state_d = CLEAR;
    endcase
  end

  // Write-port mux: sweep writes zero to entry[cnt]; RUN forwards the resolver.
  always_comb begin
    we = wen;
    wa = w_addr;
    wd = w_data;
    if (state == CLEAR) begin
      we = 1'b1;
      wa = cnt;
      wd = '0;
    end
  end

  // Table write port.
  always_ff @(posedge clk) begin
    // NOTE: the table has no reset; the sweep zeroes it, which keeps it
    // mappable onto block RAM.
    if (we) begin
      mem[wa] <= wd;
    end
  end

  // Fetch register and write-first read register (also refreshed during stall).
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
      rd_q <= '0;
    end else if (!stall) begin
      pc_q <= pc;
      if (we && (wa == pc_idx)) begin
        rd_q <= wd;
      end else begin
        rd_q <= mem[pc_idx];
      end
    end else if (we && (wa == q_idx)) begin
      rd_q <= wd;
    end
  end

  assign e_valid  = rd_q[ENTRY_W-1];
  assign e_state  = rd_q[ENTRY_W-2 -: 2];
  assign e_tag    = rd_q[PC_W +: TAG_W];
  assign e_target = rd_q[PC_W-1:0];

  // Prediction: only a tag match on a valid entry counts, and only once swept.
  assign hit          = ready & e_valid & (e_tag == pc_q[PC_W-1:ADDR_W]);
  assign state_out    = hit ? e_state : 2'b01;
  assign pc_predicted = (hit & e_state[1]) ? e_target : pc_q + PC_W'(1);

endmodule

// File: tb/tb_f_predict.sv
// Bench for f_predict: a table-level reference model pushes the expected
// outputs for every clock edge into a queue; a monitor pops and compares them
// just after the edge. A few directed checks pin the named corner cases.
module tb_f_predict;

  localparam int PC_W    = 13;
  localparam int ADDR_W  = 11;
  localparam int ENTRY_W = 18;
  localparam int DEPTH   = 2048;

  logic               clk = 1'b0;
  logic               rst;
  logic [PC_W-1:0]    pc;
  logic               stall;
  logic               ready;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_predicted;
  logic               hit;
  logic [1:0]         state_out;
  logic [ENTRY_W-1:0] w_data;
  logic [ADDR_W-1:0]  w_addr;
  logic               wen;

  always #5 clk = ~clk;

  f_predict dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .stall        (stall),
    .ready        (ready),
    .pc_q         (pc_q),
    .pc_predicted (pc_predicted),
    .hit          (hit),
    .state_out    (state_out),
    .w_data       (w_data),
    .w_addr       (w_addr),
    .wen          (wen)
  );

  typedef struct packed {
    logic            rdy;
    logic [PC_W-1:0] pcq;
    logic            h;
    logic [1:0]      st;
    logic [PC_W-1:0] pred;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a plain table, a sweep countdown, and the fetch PC.
  logic [ENTRY_W-1:0] tbl [DEPTH];
  int                 clear_left = 0;
  logic               m_ready = 1'b0;
  logic [PC_W-1:0]    m_pcq = '0;

  always @(posedge clk) begin : model
    exp_t               e;
    logic [ENTRY_W-1:0] ent;
    if (rst) begin
      clear_left = DEPTH;
      m_ready    = 1'b0;
      m_pcq      = '0;
    end else begin
      if (clear_left > 0) begin
        clear_left--;
        if (clear_left == 0) begin
          foreach (tbl[i]) tbl[i] = '0;
          m_ready = 1'b1;
        end
      end else if (wen) begin
        tbl[w_addr] = w_data;
      end
      if (!stall) m_pcq = pc;
    end
    ent    = tbl[m_pcq[ADDR_W-1:0]];
    e.rdy  = m_ready;
    e.pcq  = m_pcq;
    e.h    = m_ready && ent[17] && (ent[14:13] == m_pcq[12:11]);
    e.st   = e.h ? ent[16:15] : 2'b01;
    e.pred = (e.h && ent[16]) ? ent[12:0] : m_pcq + 13'd1;
    exp_q.push_back(e);
  end

  // Monitor: compare DUT outputs against the queued expectation after each edge.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("ready", 32'(ready), 32'(e.rdy));
      check("pc_q", 32'(pc_q), 32'(e.pcq));
      check("hit", 32'(hit), 32'(e.h));
      check("state_out", 32'(state_out), 32'(e.st));
      check("pc_predicted", 32'(pc_predicted), 32'(e.pred));
    end
  end

  task automatic drive(input logic r, input logic s, input logic [PC_W-1:0] p,
                       input logic we, input logic [ADDR_W-1:0] wa,
                       input logic [ENTRY_W-1:0] wd);
    rst    = r;
    stall  = s;
    pc     = p;
    wen    = we;
    w_addr = wa;
    w_data = wd;
    @(negedge clk);
  endtask

  logic [ADDR_W-1:0] idx_tab [8];

  initial begin
    idx_tab = '{11'h010, 11'h123, 11'h040, 11'h7FF, 11'h000, 11'h2AA, 11'h555, 11'h3C3};

    // Reset, run part of the sweep, then restart it at sweep cycle 1000.
    drive(1'b1, 1'b0, 13'h0000, 1'b0, '0, '0);
    for (int i = 0; i < 999; i++)
      drive(1'b0, 1'b0, 13'h0010, 1'($urandom % 2), 11'($urandom), 18'($urandom));
    check("sweep_pred", 32'(pc_predicted), 32'h0011);
    check("sweep_hit", 32'(hit), 32'h0);
    drive(1'b1, 1'b0, 13'h0010, 1'b0, '0, '0);
    for (int k = 1; k <= 2050; k++) begin
      drive(1'b0, 1'($urandom % 4 == 0), 13'h0010, 1'($urandom % 2),
            11'($urandom), 18'($urandom));
      if (k == 2047) check("ready_low_2047", 32'(ready), 32'h0);
      if (k == 2048) check("ready_high_2048", 32'(ready), 32'h1);
    end

    // Cold miss.
    drive(1'b0, 1'b0, 13'h0123, 1'b0, '0, '0);
    check("cold_miss_pred", 32'(pc_predicted), 32'h0124);
    check("cold_miss_state", 32'(state_out), 32'h1);

    // Taken hit, then weak state falls through.
    drive(1'b0, 1'b0, 13'h0000, 1'b1, 11'h123, {1'b1, 2'b10, 2'b00, 13'h0200});
    drive(1'b0, 1'b0, 13'h0123, 1'b0, '0, '0);
    check("taken_hit", 32'(hit), 32'h1);
    check("taken_pred", 32'(pc_predicted), 32'h0200);
    drive(1'b0, 1'b0, 13'h0000, 1'b1, 11'h123, {1'b1, 2'b01, 2'b00, 13'h0200});
    drive(1'b0, 1'b0, 13'h0123, 1'b0, '0, '0);
    check("weak_pred", 32'(pc_predicted), 32'h0124);

    // Tag alias and wrap.
    drive(1'b0, 1'b0, 13'h0923, 1'b0, '0, '0);
    check("alias_hit", 32'(hit), 32'h0);
    check("alias_pred", 32'(pc_predicted), 32'h0924);
    drive(1'b0, 1'b0, 13'h1FFF, 1'b0, '0, '0);
    check("wrap_pred", 32'(pc_predicted), 32'h0000);

    // Same-cycle forwarding, then forwarding into a stalled entry.
    drive(1'b0, 1'b0, 13'h0040, 1'b1, 11'h040, {1'b1, 2'b11, 2'b00, 13'h0050});
    check("fwd_read_pred", 32'(pc_predicted), 32'h0050);
    drive(1'b0, 1'b1, 13'h0777, 1'b1, 11'h040, {1'b1, 2'b00, 2'b00, 13'h0050});
    drive(1'b0, 1'b1, 13'h0555, 1'b0, '0, '0);
    drive(1'b0, 1'b1, 13'h0666, 1'b0, '0, '0);
    check("fwd_stall_pred", 32'(pc_predicted), 32'h0041);
    check("fwd_stall_pcq", 32'(pc_q), 32'h0040);

    // Stall hold with a changing pc, then release.
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b1, 13'(13'h0100 + i), 1'b0, '0, '0);
    check("stall_hold_pcq", 32'(pc_q), 32'h0040);
    drive(1'b0, 1'b0, 13'h0123, 1'b0, '0, '0);
    check("release_pcq", 32'(pc_q), 32'h0123);

    // Randomized traffic over a small index set so hits, aliases and forwarding recur.
    for (int i = 0; i < 3000; i++) begin
      drive(1'b0, 1'($urandom % 5 == 0),
            {2'($urandom), idx_tab[$urandom % 8]},
            1'($urandom % 3 == 0),
            idx_tab[$urandom % 8],
            {1'($urandom % 4 != 0), 2'($urandom), 2'($urandom), 13'($urandom)});
    end

    drive(1'b0, 1'b0, 13'h0000, 1'b0, '0, '0);
    drive(1'b0, 1'b0, 13'h0000, 1'b0, '0, '0);
    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
